// File: rtl/td4_pkg.sv
// Shared types and sizes for the TD4 program loader.
package td4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } loader_state_t;

  localparam int PROG_DEPTH = 16;
  localparam int INSTR_W    = 8;

endpackage

// File: rtl/prog_mem.sv
// Program memory: synchronous write and clear, asynchronous read
// for the fetch path.
module prog_mem
  import td4_pkg::*;
#(
  parameter int ADDR_W = $clog2(PROG_DEPTH),
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Streams instruction bytes into program memory and holds the
// CPU in reset until the memory is full or run is requested.
module prog_loader
  import td4_pkg::*;
#(
  parameter int ADDR_W = $clog2(PROG_DEPTH),
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_n_reset,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_addr
);

  loader_state_t state;
  logic          accept;
  logic          last;

  // A restart request discards any beat offered in the same cycle.
  assign in_ready    = (state == LOAD) && !load_req;
  assign accept      = in_valid && in_ready;
  assign last        = &wr_addr;
  assign busy        = (state == LOAD);
  assign cpu_n_reset = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_addr <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_req) begin
            state   <= LOAD;
            wr_addr <= '0;
          end else if (run_req) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (load_req) begin
            wr_addr <= '0;
          end else if (accept) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (last) begin
              state <= RUN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load_req) begin
            state   <= LOAD;
            wr_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  prog_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (wr_addr),
    .wdata (in_data),
    .raddr (cpu_addr),
    .rdata (cpu_data)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Randomised and directed checks of prog_loader against a
// behavioural model of the loader rules.
`timescale 1ns/1ps
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic       run_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_n_reset;
  logic       busy;
  logic       done;
  logic [3:0] wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: loading / running flags, next slot, contents.
  bit       m_loading;
  bit       m_running;
  bit       m_done;
  int       m_ptr;
  bit [7:0] m_mem [16];

  logic       obs_ready, exp_ready;
  logic [7:0] obs_old, exp_old;
  logic [7:0] obs_v, exp_v;

  always #20 clk = ~clk;

  prog_loader dut (
    .clk         (clk),
    .reset       (reset),
    .load_req    (load_req),
    .run_req     (run_req),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_n_reset (cpu_n_reset),
    .busy        (busy),
    .done        (done),
    .wr_addr     (wr_addr)
  );

  task automatic step(input bit r, lr, rr, v, input bit [7:0] d);
    @(negedge clk);
    reset    = r;
    load_req = lr;
    run_req  = rr;
    in_valid = v;
    in_data  = d;
    cpu_addr = 4'(m_ptr);
    #1;
    obs_ready = in_ready;
    exp_ready = m_loading && !lr;
    obs_old   = cpu_data;
    exp_old   = m_mem[m_ptr];
    @(posedge clk);
    if (r) begin
      m_loading = 0;
      m_running = 0;
      m_done    = 0;
      m_ptr     = 0;
      foreach (m_mem[i]) m_mem[i] = 8'h00;
    end else begin
      m_done = 0;
      if (lr) begin
        m_loading = 1;
        m_running = 0;
        m_ptr     = 0;
      end else if (m_loading) begin
        if (v) begin
          m_mem[m_ptr] = d;
          if (m_ptr == 15) begin
            m_loading = 0;
            m_running = 1;
            m_done    = 1;
          end
          m_ptr = (m_ptr + 1) % 16;
        end
      end else if (!m_running && rr) begin
        m_running = 1;
      end
    end
    #1;
    obs_v = {obs_ready, busy, cpu_n_reset, done, wr_addr};
    exp_v = {exp_ready, 1'(m_loading), 1'(m_running),
             1'(m_done), 4'(m_ptr)};
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 1, 1, 8'h5A);
    n_checks++;
    if (obs_v !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 00", obs_v);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mem[%0d] got %h want 00", a, cpu_data);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 8'hFF);
      n_checks++;
      if (cpu_n_reset !== 1'b0 || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold got %h want %h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_full_load;
    int dones = 0;
    step(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1, 8'(8'h30 + k));
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL full_beat%0d got %h want %h", k, obs_v, exp_v);
      end
      n_checks++;
      if (obs_old !== exp_old) begin
        n_fail++;
        $display("FAIL full_rd_old%0d got %h want %h", k, obs_old, exp_old);
      end
      if (done) begin
        dones++;
        n_checks++;
        if (cpu_n_reset !== 1'b1) begin
          n_fail++;
          $display("FAIL full_done_nrst got %b want 1", cpu_n_reset);
        end
      end
    end
    step(0, 0, 0, 0, 8'h00);
    if (done) dones++;
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL full_done_count got %0d want 1", dones);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_data !== 8'(8'h30 + a)) begin
        n_fail++;
        $display("FAIL full_mem[%0d] got %h want %h", a, cpu_data, 8'(8'h30 + a));
      end
    end
  endtask

  task automatic test_gapped;
    int k = 0;
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 1) begin
        step(0, 0, 0, 0, 8'($urandom));
      end else begin
        step(0, 0, 0, 1, 8'(8'h30 + k));
        k++;
      end
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL gap_cycle%0d got %h want %h", c, obs_v, exp_v);
      end
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_data !== 8'(8'h30 + a)) begin
        n_fail++;
        $display("FAIL gap_mem[%0d] got %h want %h", a, cpu_data, 8'(8'h30 + a));
      end
    end
  endtask

  task automatic test_restart;
    step(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'(8'hA0 + k));
    step(0, 1, 0, 1, 8'hEE);
    n_checks++;
    if (obs_ready !== 1'b0 || wr_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL restart_drop got rdy=%b addr=%0d want 0/0", obs_ready, wr_addr);
    end
    step(0, 0, 0, 1, 8'h11);
    step(0, 0, 0, 1, 8'h22);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL restart_state got %h want %h", obs_v, exp_v);
    end
    cpu_addr = 4'd0;
    #1;
    n_checks++;
    if (cpu_data !== 8'h11) begin
      n_fail++;
      $display("FAIL restart_mem0 got %h want 11", cpu_data);
    end
    cpu_addr = 4'd1;
    #1;
    n_checks++;
    if (cpu_data !== 8'h22) begin
      n_fail++;
      $display("FAIL restart_mem1 got %h want 22", cpu_data);
    end
    cpu_addr = 4'd4;
    #1;
    n_checks++;
    if (cpu_data !== 8'hA4) begin
      n_fail++;
      $display("FAIL restart_mem4 got %h want a4", cpu_data);
    end
  endtask

  task automatic test_run_reload;
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    n_checks++;
    if (cpu_n_reset !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL run_idle got nrst=%b busy=%b want 1/0", cpu_n_reset, busy);
    end
    step(0, 1, 0, 0, 8'h00);
    n_checks++;
    if (cpu_n_reset !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reload got nrst=%b busy=%b want 0/1", cpu_n_reset, busy);
    end
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h00);
    n_checks++;
    if (busy !== 1'b1 || cpu_n_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL both_req got busy=%b nrst=%b want 1/0", busy, cpu_n_reset);
    end
    for (int k = 0; k < 16; k++) step(0, 0, 1, 1, 8'($urandom));
    step(0, 0, 1, 0, 8'h00);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL run_persist got %h want %h", obs_v, exp_v);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_data !== m_mem[a]) begin
        n_fail++;
        $display("FAIL run_mem[%0d] got %h want %h", a, cpu_data, m_mem[a]);
      end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(63) == 0, $urandom_range(15) == 0,
           $urandom_range(7) == 0, $urandom_range(3) != 0,
           8'($urandom));
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL rand_ctl%0d got %h want %h", c, obs_v, exp_v);
      end
      cpu_addr = 4'($urandom);
      #1;
      n_checks++;
      if (cpu_data !== m_mem[cpu_addr]) begin
        n_fail++;
        $display("FAIL rand_rd%0d got %h want %h", c, cpu_data, m_mem[cpu_addr]);
      end
    end
  endtask

  task automatic test_reset_midload;
    step(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 8'(8'hC0 + k));
    step(1, 0, 0, 1, 8'h77);
    step(0, 0, 0, 1, 8'h99);
    n_checks++;
    if (obs_ready !== 1'b0 || busy !== 1'b0 || cpu_n_reset !== 1'b0
        || wr_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state got %h want 00", obs_v);
    end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      n_checks++;
      if (cpu_data !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_mid_mem[%0d] got %h want 00", a, cpu_data);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    load_req = 1'b0;
    run_req  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cpu_addr = 4'd0;
    test_reset;
    test_full_load;
    test_gapped;
    test_restart;
    test_run_reload;
    test_random;
    test_reset_midload;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory writer for the TD4 core. It accepts instruction bytes over a valid/ready stream, writes them into a 16×8 program memory, and holds the CPU registers (including the program counter) in reset while loading. It releases the CPU once the memory is full or run is requested. The CPU fetches from the same memory through an asynchronous read port addressed by the program counter.

## Interface
- `ADDR_W`, default 4: program address width; memory depth is 2**ADDR_W.
- `DATA_W`, default 8: instruction width.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_req`  in  1  start (or restart) a load from address 0.
- `run_req`  in  1  release the CPU without loading.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  DATA_W  instruction byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `cpu_addr`  in  ADDR_W  fetch address from the program counter.
- `cpu_data`  out  DATA_W  instruction at `cpu_addr`.
- `cpu_n_reset`  out  1  active-low reset to the CPU registers.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the last byte is written.
- `wr_addr`  out  ADDR_W  next address to be written.

## Operation
- Handshake: a beat is accepted when `in_valid && in_ready`. On acceptance, `mem[wr_addr] <= in_data` and `wr_addr <= wr_addr + 1`, modulo 2**ADDR_W.
- The FSM has three states: IDLE, LOAD, RUN.
- **IDLE**
  - `load_req` → LOAD, and `wr_addr` is set to 0.
  - else `run_req` → RUN.
  - If both are asserted, `load_req` wins.
- **LOAD**
  - `in_ready = 1`.
  - On acceptance at `wr_addr == 2**ADDR_W-1`: go to RUN, pulse `done` in the following cycle, and wrap `wr_addr` to 0.
  - `load_req` while in LOAD restarts the load: `wr_addr` becomes 0 and any beat presented that cycle is discarded (`in_ready = 0` that cycle).
  - `run_req` is ignored.
- **RUN**
  - `load_req` → LOAD with `wr_addr` set to 0, which re-holds the CPU.
  - `run_req` is ignored.
- Output decoding:
  - `in_ready` is high only in LOAD, and low in the LOAD cycle where `load_req` is high.
  - `busy` = (state == LOAD).
  - `cpu_n_reset` = (state == RUN), decoded directly from the state register so it is glitch-free.
- Memory:
  - Contents persist across LOAD→RUN→LOAD transitions.
  - A partial load keeps its earlier bytes at unwritten addresses.
  - `reset` clears all memory words to 0.

## Timing
- Reset values:
  - state IDLE, `wr_addr` 0, memory all 0.
  - `in_ready` 0, `busy` 0, `done` 0, `cpu_n_reset` 0.
  - `cpu_data` = 0 for any address.
- `reset` asserted mid-load aborts the load immediately. The next cycle is IDLE with cleared memory.
- Latency from `load_req` to `in_ready` high is one cycle. The first accepted beat is the cycle after `load_req`.
- Throughput: one byte per cycle; 16 bytes take 16 consecutive accepted cycles.
- `cpu_data` is asynchronous: it is combinational from `cpu_addr` and the memory.
  - A write at edge N is visible on `cpu_data` after edge N.
  - A same-address read in the write cycle returns the old value.
- After the last accepted beat at edge N:
  - state is RUN after edge N.
  - `cpu_n_reset` goes high after edge N.
  - `done` is high for the cycle between edges N and N+1.
- `in_valid` low stalls the load indefinitely with no timeout; `wr_addr` holds.

## Structure
- Shared package `td4_pkg`:
  - `loader_state_t` enum {IDLE, LOAD, RUN}.
  - `PROG_DEPTH` = 16.
  - `INSTR_W` = 8.
- Sub-module `prog_mem`:
  - 2**ADDR_W × DATA_W array.
  - Synchronous write port with write enable, synchronous clear on `reset`.
  - Asynchronous read port.
- `prog_loader` contains the FSM, address counter and handshake logic, and instantiates `prog_mem`.

## Test plan
- Reset, then hold: all outputs at their reset values; `cpu_data` reads 0 at `cpu_addr` 0..15; `cpu_n_reset` stays 0.
- Full load: pulse `load_req`, then stream bytes 0x30..0x3F with `in_valid` held high → 16 accepts; `done` pulses once; `cpu_n_reset` rises the same cycle as `done`; `cpu_data` at address k = 0x30+k.
- Gapped stream: drop `in_valid` every other cycle → `wr_addr` holds during gaps; final contents are identical to the full-load case.
- Restart mid-load: after 5 bytes (0xA0..0xA4), assert `load_req` with `in_valid` high and 0xEE on `in_data` → 0xEE is not written; `wr_addr` = 0; next bytes 0x11, 0x22 land at addresses 0 and 1; address 4 still holds 0xA4.
- Run and reload: `run_req` from IDLE → `cpu_n_reset` high next cycle, memory unchanged; `load_req` in RUN → `cpu_n_reset` low next cycle, `busy` high. Simultaneous `load_req` and `run_req` in IDLE → LOAD.
- Reset mid-load after 8 bytes → next cycle is IDLE, `cpu_data` = 0 at all addresses, `in_ready` 0.
